// File: rtl/mem_pkg.sv
// Shared types and the access-legality classifier for the unified memory.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef enum logic [1:0] {READ, FETCH, WRITE} access_kind_e;

  // Fetch wins over write: a fetch is always a read of the instruction region.
  function automatic access_kind_e access_kind(input logic fetch, input logic write);
    if (fetch) return FETCH;
    if (write) return WRITE;
    return READ;
  endfunction

  function automatic logic access_illegal(input logic [31:0]  addr,
                                          input access_kind_e kind,
                                          input logic [31:0]  depth,
                                          input logic [31:0]  instr_words,
                                          input logic         protect);
    if (addr >= depth) return 1'b1;
    if (kind == FETCH && addr >= instr_words) return 1'b1;
    if (kind == WRITE && protect && addr < instr_words) return 1'b1;
    return 1'b0;
  endfunction

endpackage

// File: rtl/unified_memory_if.sv
// Request/response handshake bundle between the CPU control unit and the memory.
interface unified_memory_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_fetch;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_fetch, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_fetch, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read; the read register also
// carries the zeroed response word for writes and rejected accesses.
module mem_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned AW     = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic              clr,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  // Power-up pattern: word i holds i.
  function automatic mem_t init_pattern();
    mem_t p;
    for (int unsigned i = 0; i < DEPTH; i++) p[i] = DATA_W'(i);
    return p;
  endfunction

  mem_t mem_q = init_pattern();

  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (en) rdata_d = (clr || we) ? '0 : mem_q[addr];
  end

  // Storage is never reset so committed writes survive a reset.
  always_ff @(posedge clk) begin
    if (en && we && !clr) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/unified_memory.sv
// Unified instruction/data memory: one outstanding request, configurable
// wait states, held response and region checking.
module unified_memory
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DEPTH         = 2048,
  parameter int unsigned INSTR_WORDS   = 512,
  parameter int unsigned LATENCY       = 1,
  parameter int unsigned PROTECT_INSTR = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  unified_memory_if.slave  bus
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  state_e             state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               err_d, err_q;
  logic               rsp_valid_d, rsp_valid_q;
  logic               req_ready_d, req_ready_q;
  logic [ADDR_W-1:0]  addr_c;
  logic [DATA_W-1:0]  rdata;
  access_kind_e       kind_c;
  logic               illegal_c;
  logic               accept_c;

  assign addr_c    = bus.req_addr;
  assign kind_c    = access_kind(bus.req_fetch, bus.req_write);
  assign illegal_c = access_illegal(32'(addr_c), kind_c, 32'(DEPTH),
                                    32'(INSTR_WORDS), PROTECT_INSTR != 0);
  assign accept_c  = bus.req_valid && req_ready_q;

  mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept_c),
    .we    (kind_c == WRITE),
    .clr   (illegal_c),
    .addr  (addr_c[AW-1:0]),
    .wdata (bus.req_wdata),
    .rdata (rdata)
  );

  // Next-state, wait counter and response classification.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          err_d = illegal_c;
          if (LATENCY <= 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rdata;
  assign bus.rsp_err   = err_q;

endmodule
